// File: rtl/servo_pwm_decoder_pkg.sv
`default_nettype none
// ============================================================================
// servo_pkg : shared constants, FSM encoding and width type for servo_pwm_decoder
// Rev 1.0
// ============================================================================
package servo_pkg;

  localparam int CLK_HZ      = 50_000_000;
  localparam int SERVO_MIN_W = 20_000;
  localparam int SERVO_MAX_W = 120_000;
  localparam int ANGLE_MAX   = 180;

  localparam int WIDTH_W = 20;
  localparam int NUM_W   = 28;
  localparam int DEN_W   = 17;

  typedef logic [WIDTH_W-1:0] width_t;

  typedef enum logic [2:0] {
    ARM       = 3'd0,
    WAIT_RISE = 3'd1,
    HIGH      = 3'd2,
    CHECK     = 3'd3,
    CALC      = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/servo_pwm_decoder_div_seq.sv
`default_nettype none
// ============================================================================
// servo_div_seq : sequential restoring divider, one quotient bit per cycle,
// start/done handshake. Rev 1.0
// ============================================================================
module servo_div_seq #(
  parameter int NUM_W = 28,
  parameter int DEN_W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [NUM_W-1:0] num_i,
  input  logic [DEN_W-1:0] den_i,
  output logic [NUM_W-1:0] quo_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CNT_W = $clog2(NUM_W) + 1;

  logic [DEN_W-1:0] rem_q, rem_d;
  logic [NUM_W-1:0] quo_q, quo_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [DEN_W-1:0] src_rem, src_den, step_rem;
  logic [NUM_W-1:0] src_quo, step_quo;
  logic [DEN_W:0]   shifted;
  logic             step_bit;

  // The first iteration runs in the start cycle, so NUM_W bits finish
  // NUM_W edges after start is sampled.
  always_comb begin
    src_rem = start_i ? '0 : rem_q;
    src_quo = start_i ? num_i : quo_q;
    src_den = start_i ? den_i : den_q;

    shifted = {src_rem, src_quo[NUM_W-1]};
    if (shifted >= {1'b0, src_den}) begin
      step_rem = DEN_W'(shifted - {1'b0, src_den});
      step_bit = 1'b1;
    end else begin
      step_rem = shifted[DEN_W-1:0];
      step_bit = 1'b0;
    end
    step_quo = {src_quo[NUM_W-2:0], step_bit};

    rem_d  = rem_q;
    quo_d  = quo_q;
    den_d  = den_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;

    if (start_i) begin
      rem_d  = step_rem;
      quo_d  = step_quo;
      den_d  = den_i;
      cnt_d  = CNT_W'(1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = step_rem;
      quo_d = step_quo;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(NUM_W - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      den_q  <= den_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign quo_o  = quo_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule
`default_nettype wire

// File: rtl/servo_pwm_decoder.sv
`default_nettype none
// ============================================================================
// servo_pwm_decoder : measures servo PWM high pulses and converts them to 0..180
// degrees; optional SERVO_GLITCH_FILTER_EN debounces the line. Rev 1.0
// ============================================================================
module servo_pwm_decoder
  import servo_pkg::*;
#(
  parameter int MIN_WIDTH   = SERVO_MIN_W,
  parameter int MAX_WIDTH   = SERVO_MAX_W,
  parameter int LOST_CYCLES = 2_000_000,
  parameter int FILT_LEN    = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pwm_in,
  output width_t       width_o,
  output logic [7:0]   angle_o,
  output logic         valid_o,
  output logic         err_range_o,
  output logic         signal_lost_o,
  output logic         busy_o
);

  localparam int LOST_W = $clog2(LOST_CYCLES + 1);
`ifdef SERVO_GLITCH_FILTER_EN
  localparam int FILT_W       = $clog2(FILT_LEN) + 1;
  localparam int PRIME_CYCLES = 3 + FILT_LEN;
`else
  localparam int PRIME_CYCLES = 2;
`endif
  localparam int PRIME_W = $clog2(PRIME_CYCLES + 1);

  if (FILT_LEN < 1) begin : g_filt_len_check
    $error("FILT_LEN must be at least 1");
  end
  if (MIN_WIDTH >= MAX_WIDTH) begin : g_range_check
    $error("MIN_WIDTH must be below MAX_WIDTH");
  end

  logic               sync1_q, sync1_d, sync2_q, sync2_d, s_prev_q, s_prev_d;
  logic [PRIME_W-1:0] prime_q, prime_d;
  state_e             state_q, state_d;
  width_t             cnt_q, cnt_d, cap_q, cap_d, width_q, width_d;
  logic [7:0]         angle_q, angle_d;
  logic               valid_q, valid_d, err_q, err_d, lost_q, lost_d, busy_q, busy_d;
  logic [LOST_W-1:0]  lost_cnt_q, lost_cnt_d;

  logic               s, rise, fall, primed, lost_hit, div_start;
  logic [NUM_W-1:0]   div_num, div_quo;
  logic [DEN_W-1:0]   div_den;
  logic               div_busy, div_done;

`ifdef SERVO_GLITCH_FILTER_EN
  logic               filt_q, filt_d;
  logic [FILT_W-1:0]  filt_cnt_q, filt_cnt_d;

  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (sync2_q != filt_q) begin
      if (filt_cnt_q == FILT_W'(FILT_LEN - 1)) filt_d = sync2_q;
      else                                     filt_cnt_d = filt_cnt_q + 1'b1;
    end
  end
  assign s = filt_q;
`else
  assign s = sync2_q;
`endif

  // Synchronizer flops reset low, so s reads low before the pin has really
  // been sampled; ARM waits until the pipeline is primed before trusting it.
  assign primed   = (prime_q == PRIME_W'(PRIME_CYCLES));
  assign rise     = s & ~s_prev_q;
  assign fall     = ~s & s_prev_q;
  assign lost_hit = ~rise & (lost_cnt_q == LOST_W'(LOST_CYCLES - 1));
  assign div_num  = NUM_W'(cap_q - WIDTH_W'(MIN_WIDTH)) * NUM_W'(ANGLE_MAX);
  assign div_den  = DEN_W'(MAX_WIDTH - MIN_WIDTH);

  always_comb begin
    sync1_d    = pwm_in;
    sync2_d    = sync1_q;
    s_prev_d   = s;
    prime_d    = primed ? prime_q : prime_q + 1'b1;
    state_d    = state_q;
    cnt_d      = cnt_q;
    cap_d      = cap_q;
    width_d    = width_q;
    angle_d    = angle_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    lost_d     = lost_q;
    div_start  = 1'b0;

    if (rise)                                      lost_cnt_d = '0;
    else if (lost_cnt_q != LOST_W'(LOST_CYCLES))   lost_cnt_d = lost_cnt_q + 1'b1;
    else                                           lost_cnt_d = lost_cnt_q;

    case (state_q)
      ARM: if (primed && !s) state_d = WAIT_RISE;
      WAIT_RISE: begin
        if (rise) begin
          cnt_d   = WIDTH_W'(1);
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          cap_d   = cnt_q;
          state_d = CHECK;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CHECK: begin
        if (cap_q < WIDTH_W'(MIN_WIDTH) || cap_q > WIDTH_W'(MAX_WIDTH)) begin
          err_d   = 1'b1;
          state_d = WAIT_RISE;
        end else begin
          div_start = 1'b1;
          state_d   = CALC;
        end
      end
      CALC: begin
        if (div_done) begin
          width_d = cap_q;
          // In-range widths never exceed ANGLE_MAX; the clamp just keeps all
          // quotient bits meaningful.
          angle_d = (div_quo > NUM_W'(ANGLE_MAX)) ? 8'(ANGLE_MAX) : div_quo[7:0];
          valid_d = 1'b1;
          lost_d  = 1'b0;
          state_d = WAIT_RISE;
        end else if (!div_busy) begin
          state_d = WAIT_RISE;
        end
      end
      default: state_d = ARM;
    endcase

    if (lost_hit) begin
      lost_d  = 1'b1;
      state_d = ARM;
    end

    busy_d = (state_d == CALC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      s_prev_q   <= 1'b0;
      prime_q    <= '0;
      state_q    <= ARM;
      cnt_q      <= '0;
      cap_q      <= '0;
      width_q    <= '0;
      angle_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      lost_q     <= 1'b0;
      busy_q     <= 1'b0;
      lost_cnt_q <= '0;
`ifdef SERVO_GLITCH_FILTER_EN
      filt_q     <= 1'b0;
      filt_cnt_q <= '0;
`endif
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      s_prev_q   <= s_prev_d;
      prime_q    <= prime_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_q      <= cap_d;
      width_q    <= width_d;
      angle_q    <= angle_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      lost_q     <= lost_d;
      busy_q     <= busy_d;
      lost_cnt_q <= lost_cnt_d;
`ifdef SERVO_GLITCH_FILTER_EN
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
`endif
    end
  end

  servo_div_seq #(
    .NUM_W (NUM_W),
    .DEN_W (DEN_W)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start_i (div_start),
    .num_i   (div_num),
    .den_i   (div_den),
    .quo_o   (div_quo),
    .busy_o  (div_busy),
    .done_o  (div_done)
  );

  assign width_o       = width_q;
  assign angle_o       = angle_q;
  assign valid_o       = valid_q;
  assign err_range_o   = err_q;
  assign signal_lost_o = lost_q;
  assign busy_o        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_decoder.sv
`default_nettype none
// ============================================================================
// tb_servo_pwm_decoder : table-driven pulses plus loss/reset/glitch sequences,
// results checked through an expected-output queue. Rev 1.0
// ============================================================================
module tb_servo_pwm_decoder;

  localparam int MINW = 200;
  localparam int MAXW = 1200;
  localparam int LOST = 3000;
  localparam int FLEN = 4;
`ifdef SERVO_GLITCH_FILTER_EN
  localparam int FX = FLEN;
`else
  localparam int FX = 0;
`endif
  localparam int LAT = 32 + FX;   // pin fall -> valid_o, incl. 2 sync stages
  localparam int WIN = 60;
  localparam int NV  = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pwm_in = 1'b0;
  logic [19:0] width_o;
  logic [7:0]  angle_o;
  logic        valid_o, err_range_o, signal_lost_o, busy_o;

  servo_pwm_decoder #(
    .MIN_WIDTH   (MINW),
    .MAX_WIDTH   (MAXW),
    .LOST_CYCLES (LOST),
    .FILT_LEN    (FLEN)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pwm_in        (pwm_in),
    .width_o       (width_o),
    .angle_o       (angle_o),
    .valid_o       (valid_o),
    .err_range_o   (err_range_o),
    .signal_lost_o (signal_lost_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int width; int angle;} exp_t;
  typedef struct {int width; bit ok; int angle;} vec_t;

  exp_t exp_q[$];
  vec_t vecs[NV];
  int   checks = 0, errors = 0;
  int   n_valid = 0, n_err = 0, n_busy = 0;
  int   valid_cyc = 0, rise_cyc = 0, fall_cyc = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every valid strobe.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (valid_o) begin
        n_valid++;
        valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got width %0d, want no output", width_o);
        end else begin
          e = exp_q.pop_front();
          check("valid_width", width_o, e.width);
          check("valid_angle", angle_o, e.angle);
          check("lost_clear_on_valid", signal_lost_o, 0);
        end
      end
      if (err_range_o) n_err++;
      if (busy_o) n_busy++;
    end
  end

  task automatic run_pulse(input int w, input bit ok, input int ang, input string tag);
    int prev_w, prev_a;
    prev_w = width_o;
    prev_a = angle_o;
    if (ok) exp_q.push_back('{w, ang});
    @(posedge clk); #1;
    pwm_in = 1'b1;
    rise_cyc = cyc;
    n_valid = 0; n_err = 0; n_busy = 0;
    repeat (w) @(posedge clk);
    #1;
    pwm_in = 1'b0;
    fall_cyc = cyc;
    repeat (WIN) @(posedge clk);
    #2;
    if (ok) begin
      check({tag, "_nvalid"}, n_valid, 1);
      check({tag, "_nerr"}, n_err, 0);
      check({tag, "_latency"}, valid_cyc - fall_cyc, LAT);
      check({tag, "_busy_cycles"}, n_busy, 28);
    end else begin
      check({tag, "_nerr"}, n_err, 1);
      check({tag, "_nvalid"}, n_valid, 0);
      check({tag, "_busy_cycles"}, n_busy, 0);
      check({tag, "_width_hold"}, width_o, prev_w);
      check({tag, "_angle_hold"}, angle_o, prev_a);
    end
  endtask

  initial begin
    int lost_cyc;

    vecs[0] = '{656,  1'b1, 82};
    vecs[1] = '{200,  1'b1, 0};
    vecs[2] = '{1200, 1'b1, 180};
    vecs[3] = '{950,  1'b1, 135};
    vecs[4] = '{199,  1'b0, 0};
    vecs[5] = '{1201, 1'b0, 0};
    vecs[6] = '{700,  1'b1, 90};
    vecs[7] = '{201,  1'b1, 0};
    vecs[8] = '{150,  1'b0, 0};
    vecs[9] = '{1199, 1'b1, 179};

    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_width", width_o, 0);
    check("rst_angle", angle_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_err", err_range_o, 0);
    check("rst_lost", signal_lost_o, 0);
    check("rst_busy", busy_o, 0);
    repeat (20) @(posedge clk);

    for (int i = 0; i < NV; i++)
      run_pulse(vecs[i].width, vecs[i].ok, vecs[i].angle, $sformatf("vec%0d", i));

    // Loss of signal: line idles low after the last rising edge.
    check("lost_before_timeout", signal_lost_o, 0);
    lost_cyc = -1;
    for (int i = 0; i < LOST + 200 && lost_cyc < 0; i++) begin
      @(posedge clk); #1;
      if (signal_lost_o) lost_cyc = cyc;
    end
    check("lost_time", lost_cyc, rise_cyc + 3 + LOST + FX);
    check("lost_width_hold", width_o, 1199);
    check("lost_angle_hold", angle_o, 179);
    run_pulse(445, 1'b1, 44, "post_loss");
    check("post_loss_lost", signal_lost_o, 0);

    // Two-cycle low glitch inside an otherwise valid pulse.
`ifdef SERVO_GLITCH_FILTER_EN
    exp_q.push_back('{867, 120});
`else
    exp_q.push_back('{400, 36});
`endif
    @(posedge clk); #1;
    n_valid = 0; n_err = 0;
    pwm_in = 1'b1;
    repeat (400) @(posedge clk);
    #1; pwm_in = 1'b0;
    repeat (2) @(posedge clk);
    #1; pwm_in = 1'b1;
    repeat (465) @(posedge clk);
    #1; pwm_in = 1'b0;
    repeat (WIN) @(posedge clk);
    #2;
    check("glitch_nvalid", n_valid, 1);
    check("glitch_nerr", n_err, 0);

    // Reset in the middle of a pulse, released while the pin is still high.
    @(posedge clk); #1;
    pwm_in = 1'b1;
    repeat (300) @(posedge clk);
    #1; rst = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    n_valid = 0; n_err = 0;
    check("midrst_width", width_o, 0);
    check("midrst_angle", angle_o, 0);
    repeat (400) @(posedge clk);
    #1; pwm_in = 1'b0;
    repeat (WIN) @(posedge clk);
    #2;
    check("midrst_nvalid", n_valid, 0);
    check("midrst_nerr", n_err, 0);
    run_pulse(867, 1'b1, 120, "after_rst");

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
